// File: rtl/mdu_pkg.sv
// Shared encodings for the sequential signed multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; used for operand magnitudes and result fix-up.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;
endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring) unit sharing one 2*WIDTH accumulator.
// Works on magnitudes for WIDTH cycles, then restores the signs before writing HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mult_div_unit_if.slave        bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  mdu_state_e             state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   op_q, op_d;
  logic                   neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                   done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0]       abs_a, abs_b, res_lo, res_hi_neg, res_hi;
  logic [WIDTH:0]         mul_sum, div_trial;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .data_i (bus.a),
    .neg_i  (bus.a[WIDTH-1]),
    .data_o (abs_a)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .data_i (bus.b),
    .neg_i  (bus.b[WIDTH-1]),
    .data_o (abs_b)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_lo (
    .data_i (acc_q[WIDTH-1:0]),
    .neg_i  (neg_lo_q),
    .data_o (res_lo)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_hi (
    .data_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i  (neg_hi_q),
    .data_o (res_hi_neg)
  );

  // A negated 64-bit product only carries into the upper word when the lower word is zero.
  assign res_hi = (op_q == MDU_MULT && neg_lo_q && acc_q[WIDTH-1:0] != '0) ?
                  ~acc_q[2*WIDTH-1:WIDTH] : res_hi_neg;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Remainder stays below the divisor magnitude, so WIDTH+1 bits cover the shifted value.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d     = bus.op;
          opnd_d   = abs_b;
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          cnt_d    = '0;
          neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          neg_hi_d = (bus.op == MDU_DIV) ? bus.a[WIDTH-1] : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          if (bus.op == MDU_DIV && bus.b == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == MDU_MULT) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_trial[WIDTH]) begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      op_q     <= MDU_MULT;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed expected results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one op and counts cycles until done; optionally injects a stray start at cycle 10.
  task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input bit inject, output int n, output logic dz,
                        output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    n      = 0;
    dz     = 1'b0;
    mid_hi = 'x;
    mid_lo = 'x;
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.a     = a_v;
    bus.b     = b_v;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      if (inject && n == 10) begin
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
      end
      if (n == 10) begin
        mid_hi = bus.hi;
        mid_lo = bus.lo;
      end
      if (bus.done) begin
        dz = bus.div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    #3;
    total += 5;
    if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.div_zero !== 1'b0) begin
      bad++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    logic dz;
    logic [31:0] mh, ml;
    run_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, n, dz, mh, ml);
    total += 5;
    if (n !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", n); end
    if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", bus.lo); end
    if (dz !== 1'b0) begin bad++; $display("FAIL mult_dz got=%b exp=0", dz); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL done_busy got=%b exp=1", bus.busy); end
    @(posedge clk);
    #1;
    total += 2;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", bus.done); end

    run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, n, dz, mh, ml);
    total += 4;
    if (mh !== 32'hFFFF_FFFF || ml !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mult_hold got=%h_%h exp=ffffffff_ffffffeb", mh, ml);
    end
    if (n !== 34) begin bad++; $display("FAIL mult_min_latency got=%0d exp=34", n); end
    if (bus.hi !== 32'h4000_0000) begin bad++; $display("FAIL mult_min_hi got=%h exp=40000000", bus.hi); end
    if (bus.lo !== 32'h0) begin bad++; $display("FAIL mult_min_lo got=%h exp=0", bus.lo); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div();
    int n;
    logic dz;
    logic [31:0] mh, ml;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n, dz, mh, ml);
    total += 5;
    if (mh !== 32'h4000_0000 || ml !== 32'h0) begin
      bad++; $display("FAIL div_hold got=%h_%h exp=40000000_00000000", mh, ml);
    end
    if (n !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", n); end
    if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_q got=%h exp=fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_r got=%h exp=ffffffff", bus.hi); end
    if (dz !== 1'b0) begin bad++; $display("FAIL div_dz got=%b exp=0", dz); end
    @(posedge clk);
    #1;
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, dz, mh, ml);
    total += 2;
    if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_q got=%h exp=80000000", bus.lo); end
    if (bus.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_r got=%h exp=0", bus.hi); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero();
    int n;
    logic dz;
    logic [31:0] mh, ml;
    run_op(MDU_DIV, 32'd5, 32'd2, 1'b0, n, dz, mh, ml);
    total += 2;
    if (bus.lo !== 32'h2) begin bad++; $display("FAIL div_pos_q got=%h exp=2", bus.lo); end
    if (bus.hi !== 32'h1) begin bad++; $display("FAIL div_pos_r got=%h exp=1", bus.hi); end
    @(posedge clk);
    #1;
    run_op(MDU_DIV, 32'd5, 32'd0, 1'b0, n, dz, mh, ml);
    total += 4;
    if (n !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", n); end
    if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    if (bus.hi !== 32'h1) begin bad++; $display("FAIL dz_hi got=%h exp=1", bus.hi); end
    if (bus.lo !== 32'h2) begin bad++; $display("FAIL dz_lo got=%h exp=2", bus.lo); end
    @(posedge clk);
    #1;
    total += 2;
    if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL dz_pulse got=%b exp=0", bus.div_zero); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL dz_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic dz;
    logic [31:0] mh, ml;
    run_op(MDU_MULT, 32'd3, 32'd4, 1'b1, n, dz, mh, ml);
    total += 3;
    if (n !== 34) begin bad++; $display("FAIL ign_latency got=%0d exp=34", n); end
    if (bus.hi !== 32'h0) begin bad++; $display("FAIL ign_hi got=%h exp=0", bus.hi); end
    if (bus.lo !== 32'd12) begin bad++; $display("FAIL ign_lo got=%h exp=c", bus.lo); end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    total += 1;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_not_queued got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    int n;
    logic dz;
    logic [31:0] mh, ml;
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    repeat (20) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    total += 4;
    if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_lo got=%h exp=0", bus.lo); end
    if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_hi got=%h exp=0", bus.hi); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b exp=00", bus.done, bus.div_zero);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_op(MDU_MULT, 32'd2, 32'd2, 1'b0, n, dz, mh, ml);
    total += 3;
    if (n !== 34) begin bad++; $display("FAIL rst_mult_latency got=%0d exp=34", n); end
    if (bus.lo !== 32'd4) begin bad++; $display("FAIL rst_mult_lo got=%h exp=4", bus.lo); end
    if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_mult_hi got=%h exp=0", bus.hi); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int n;
    int t1;
    int t2;
    t1 = 0;
    t2 = 0;
    n  = 0;
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.a     = 32'hFFFF_FFFE;
    bus.b     = 32'd3;
    while (n < 120 && t2 == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) begin
        if (t1 == 0) t1 = n;
        else t2 = n;
      end
    end
    bus.start = 1'b0;
    total += 4;
    if (t1 !== 34) begin bad++; $display("FAIL b2b_first got=%0d exp=34", t1); end
    if (t2 - t1 !== 35) begin bad++; $display("FAIL b2b_period got=%0d exp=35", t2 - t1); end
    if (bus.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL b2b_lo got=%h exp=fffffffa", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_hi got=%h exp=ffffffff", bus.hi); end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
